// File: rtl/mips_ft_pkg.sv
// Shared definitions for the triple-redundant (TMR) pipeline stages.
package mips_ft_pkg;
  localparam int NCOPY            = 3;
  localparam int DEF_WIDTH        = 32;
  localparam int DEF_CNT_W        = 4;
  localparam int DEF_FAULT_THRESH = 3;

  typedef logic [1:0] copy_idx_t;

  // Stored word at the default width: the zero flag rides above the result.
  typedef struct packed {
    logic                 zero;
    logic [DEF_WIDTH-1:0] result;
  } word_t;

  function automatic int ones3(input logic [2:0] v);
    return int'(v[0]) + int'(v[1]) + int'(v[2]);
  endfunction
endpackage

// File: rtl/voter3.sv
// Masked 2-of-3 voter on one W-bit word. Masked copies never reach the vote.
// With one copy masked the two survivors must agree; otherwise the lower-indexed
// survivor is passed through and the result is flagged uncorrectable.
module voter3
  import mips_ft_pkg::*;
#(
  parameter int W = DEF_WIDTH + 1
) (
  input  logic [NCOPY-1:0][W-1:0] word,
  input  logic [NCOPY-1:0]        mask,
  output logic [W-1:0]            vote,
  output logic [NCOPY-1:0]        mismatch,
  output logic                    uncorrectable
);
  logic [W-1:0] maj, a, b;

  // Pick the vote from however many copies are still trusted.
  always_comb begin
    maj           = (word[0] & word[1]) | (word[0] & word[2]) | (word[1] & word[2]);
    // survivors when exactly one copy is masked; a is the lower index
    a             = mask[0] ? word[1] : word[0];
    b             = mask[2] ? word[1] : word[2];
    vote          = maj;
    uncorrectable = 1'b0;
    case (mask)
      3'b000:                 vote = maj;
      3'b001, 3'b010, 3'b100: begin
        vote          = a;
        uncorrectable = (a != b);
      end
      3'b011:  vote = word[2];
      3'b101:  vote = word[1];
      3'b110:  vote = word[0];
      default: vote = word[0];
    endcase
    mismatch = '0;
    for (int i = 0; i < NCOPY; i++)
      mismatch[i] = !mask[i] && (word[i] != vote);
  end
endmodule

// File: rtl/alu_result_stage.sv
// TMR result register behind the ALU: single-entry valid/ready buffer holding
// three copies of {zero, result}, voted every cycle, with scrubbing, per-copy
// saturating error counters and sticky masking of copies that keep failing.
// Optional fault injection port set is enabled with FAULT_INJECT_EN.
module alu_result_stage
  import mips_ft_pkg::*;
#(
  parameter int WIDTH        = DEF_WIDTH,
  parameter int CNT_W        = DEF_CNT_W,
  parameter int FAULT_THRESH = DEF_FAULT_THRESH
) (
  input  logic                   clk,
  input  logic                   reset_n,
`ifdef FAULT_INJECT_EN
  input  logic                   inj_en,
  input  logic [1:0]             inj_copy,
  input  logic [WIDTH:0]         inj_mask,
`endif
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       result_in,
  input  logic                   zero_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       result_out,
  output logic                   zero_out,
  output logic [NCOPY-1:0]       fault_mask,
  output logic [3*CNT_W-1:0]     err_cnt,
  output logic                   uncorrectable
);
  localparam int               WW      = WIDTH + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] THRESH  = CNT_W'(FAULT_THRESH);

  logic                         full, load, v_unc;
  logic [NCOPY-1:0][WW-1:0]     copy_q;
  logic [NCOPY-1:0][CNT_W-1:0]  cnt_q, cnt_d;
  logic [NCOPY-1:0]             mask_q, mask_d, mism, bump, inj_hit;
  logic [WW-1:0]                vote, in_word, inj_word;

  assign in_ready = !full || out_ready;
  assign load     = in_valid && in_ready;
  assign in_word  = {zero_in, result_in};

  voter3 #(.W(WW)) u_vote (
    .word          (copy_q),
    .mask          (mask_q),
    .vote          (vote),
    .mismatch      (mism),
    .uncorrectable (v_unc)
  );

`ifdef FAULT_INJECT_EN
  assign inj_word = inj_mask;
  // Select the injected copy; index 3 matches nothing.
  always_comb begin
    inj_hit = '0;
    for (int i = 0; i < NCOPY; i++)
      inj_hit[i] = inj_en && full && (inj_copy == copy_idx_t'(i));
  end
`else
  assign inj_word = '0;
  assign inj_hit  = '0;
`endif

  // Count mismatches (not while the vote itself is untrusted) and mask copies
  // at threshold, lowest index first, never masking the last survivor.
  always_comb begin
    cnt_d  = cnt_q;
    mask_d = mask_q;
    bump   = '0;
    for (int i = 0; i < NCOPY; i++) begin
      bump[i] = full && mism[i] && !v_unc;
      if (bump[i] && cnt_q[i] != CNT_MAX)
        cnt_d[i] = cnt_q[i] + 1'b1;
      if (bump[i] && cnt_d[i] >= THRESH && !mask_d[i] && ones3(mask_d) < 2)
        mask_d[i] = 1'b1;
    end
  end

  // Buffer state, copies (load > inject > scrub), counters and masks.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      full   <= 1'b0;
      copy_q <= '0;
      cnt_q  <= '0;
      mask_q <= '0;
    end else begin
      full   <= load || (full && !out_ready);
      cnt_q  <= cnt_d;
      mask_q <= mask_d;
      for (int i = 0; i < NCOPY; i++) begin
        if (load)                copy_q[i] <= in_word;
        else if (inj_hit[i])     copy_q[i] <= copy_q[i] ^ inj_word;
        else if (full && mism[i]) copy_q[i] <= vote;
      end
    end
  end

  assign out_valid     = full;
  assign result_out    = vote[WIDTH-1:0];
  assign zero_out      = vote[WIDTH];
  assign uncorrectable = full && v_unc;
  assign fault_mask    = mask_q;
  assign err_cnt       = cnt_q;
endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Triple-redundant pipeline register directly downstream of the ALU. It captures the ALU result and zero flag and holds them for the writeback/branch stage.
- Each cycle it majority-votes the three stored copies, scrubs any copy that disagrees with the vote, and counts per-copy errors.
- A copy that reaches the error threshold is permanently masked until reset.
- A valid/ready handshake lets the downstream stage stall the pipe.

Parameters:
- WIDTH, 32, ALU result width; each stored word is WIDTH+1 bits, {zero, result}.
- CNT_W, 4, width of each per-copy error counter (saturating).
- FAULT_THRESH, 3, error count at which a copy is masked; must be 1 to 2^CNT_W-1.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- in_valid  in  1  ALU result valid.
- in_ready  out  1  stage can accept a result this cycle.
- result_in  in  WIDTH  ALU result.
- zero_in  in  1  ALU zero flag.
- out_valid  out  1  held result valid.
- out_ready  in  1  downstream accepts this cycle.
- result_out  out  WIDTH  voted result.
- zero_out  out  1  voted zero flag.
- fault_mask  out  3  bit i set = copy i masked (sticky).
- err_cnt  out  3*CNT_W  per-copy saturating error counts; copy 0 in the LSBs.
- uncorrectable  out  1  voted output not trustworthy this cycle.

Behaviour:
- Reset (asynchronous, reset_n low): copies, counters and fault_mask all cleared to 0; out_valid=0; result_out=0; zero_out=0; uncorrectable=0.
- Buffer: single entry, with full = out_valid.
  - in_ready = !full || out_ready (combinational).
  - load = in_valid && in_ready. On load, all three copies are written with {zero_in, result_in}, and full=1 next cycle.
  - If out_ready && full && !load: full=0 next cycle.
  - Latency: 1 cycle from load to out_valid. Back-to-back throughput is 1 per cycle.
  - When empty, copies hold their old values but are not compared.
- Vote (combinational on the stored copies, drives result_out/zero_out):
  - 0 copies masked: bitwise 2-of-3 majority; uncorrectable=0.
  - 1 copy masked: the two remaining copies are compared. Equal: output that value. Unequal: output the lower-indexed unmasked copy and set uncorrectable=1 (when full).
  - 2 copies masked: output the single remaining copy; uncorrectable=0.
  - Masked copies never contribute to the vote.
- Check and scrub (every cycle with full=1):
  - Copy i mismatches if it is unmasked and differs from the vote in any bit.
  - A mismatch increments err_cnt[i], saturating at 2^CNT_W-1.
  - If !load, the mismatching copy is overwritten with the voted word next cycle.
  - If load in the same cycle, the load data overwrites all copies and the mismatch is still counted.
  - A mismatch while uncorrectable=1 does not increment any counter.
- Masking:
  - When err_cnt[i] reaches FAULT_THRESH, fault_mask[i] is set on the same edge as the increment.
  - The mask is sticky until reset.
  - The last unmasked copy is never masked; its counter still saturates.
  - Masking takes effect on the vote from the next cycle.
- Result and zero are voted as one WIDTH+1 word, so a zero-only error counts once.
- result_out, zero_out and uncorrectable are valid only while out_valid=1.
- reset_n asserted mid-transfer discards the held entry; there is no partial state.

Optional Feature:
- Macro FAULT_INJECT_EN.
- Defined: adds ports inj_en (in, 1), inj_copy (in, 2) and inj_mask (in, WIDTH+1).
  - When inj_en=1 and full, the selected copy is XORed with inj_mask at the clock edge. This takes priority over scrub for that copy; load still wins.
  - inj_copy=3 is ignored.
- Undefined: no extra ports and no injection logic.

Decomposition:
- Package mips_ft_pkg:
  - NCOPY=3.
  - Copy index typedef (2 bits).
  - Typedef for the stored word {zero, result}.
  - Default FAULT_THRESH and CNT_W.
- Sub-module voter3: combinational masked 2-of-3 vote on a WIDTH+1 word. Outputs are the vote, a per-copy mismatch vector and the uncorrectable flag. It is reused by other TMR stages.

Test Plan:
- Load 0x0000_0005 (zero=0) with out_ready=1 -> out_valid next cycle, result_out=0x5, no errors, in_ready stays 1; back-to-back loads emerge one per cycle.
- Hold with out_ready=0, then in_valid=1 with 0xDEAD_BEEF -> in_ready=0 and the held value is unchanged; raise out_ready -> old value consumed, new value loaded the same cycle.
- Corrupt copy 1 bit 0 with 0x1 (inject) -> result_out stays the correct value, err_cnt[1]=1, copy 1 restored next cycle.
- Repeat the copy 1 corruption 3 times (threshold 3) -> fault_mask=3'b010 after the 3rd error; further copy 1 injections do not change the output or counters.
- With copy 1 masked, corrupt copy 0 -> uncorrectable=1 and result_out = copy 0 value; copy 0 is not masked.
- Deassert reset_n mid-hold with counters non-zero -> out_valid=0, fault_mask=0, all err_cnt=0 immediately (asynchronous).
